// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample scheduler: code width, FSM state
// encoding and small index helpers used by the scheduler and its arbiter.
package adc_pkg;

    localparam int ADC_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Requester index width; a single requester still gets a 1-bit ID.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment modulo n, safe for non-power-of-two requester counts.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/adc_sample_sched_if.sv
// Client-side bundle of the ADC scheduler: request/ack pairs, the result
// valid/ready port and the busy flag. The scheduler uses the slave modport,
// the clients (or a bench) use the master modport.
interface adc_sample_sched_if #(
    parameter int BITS = adc_pkg::ADC_BITS,
    parameter int NREQ = 4
);
    localparam int IDW = adc_pkg::id_width(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            res_valid;
    logic            res_ready;
    logic [BITS-1:0] res_data;
    logic [IDW-1:0]  res_id;
    logic            busy;

    modport slave (
        input  req,
        input  res_ready,
        output ack,
        output res_valid,
        output res_data,
        output res_id,
        output busy
    );

    modport master (
        output req,
        output res_ready,
        input  ack,
        input  res_valid,
        input  res_data,
        input  res_id,
        input  busy
    );

endinterface

// File: rtl/adc_sample_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search for an active request starts
// at ptr_i and wraps; returns a one-hot grant plus the binary winner index.
module rr_arbiter
    import adc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    // First active request at or after the pointer, wrapping around.
    always_comb begin
        logic [IDW-1:0] cand;
        // NOTE: every output and temporary gets a default first, so no path through this block can infer a latch.
        cand    = '0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/adc_sample_sched.sv
// Scheduler for the shared SAR ADC: arbitrates client requests, drives a
// registered sample clock with a fixed high time, captures the ADC code at a
// fixed settle point and hands it back with the owner ID over valid/ready.
// Successive sample-clock rising edges are never closer than PERIOD_MIN.
module adc_sample_sched
    import adc_pkg::*;
#(
    parameter int BITS       = ADC_BITS,
    parameter int NREQ       = 4,
    parameter int CLK_HIGH   = 4,
    parameter int SETTLE     = 6,
    parameter int PERIOD_MIN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    adc_sample_sched_if.slave bus,
    output logic              adc_clk_o,
    input  logic [BITS-1:0]   adc_data_i
);

    localparam int IDW = id_width(NREQ);
    localparam int TW  = $clog2(PERIOD_MIN + 1);

    localparam logic [TW-1:0] T_HIGH   = TW'(CLK_HIGH);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE);
    localparam logic [TW-1:0] T_PERIOD = TW'(PERIOD_MIN);

    state_e          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;      // cycles since the adc_clk rise, 1-based
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            adc_clk_q, adc_clk_d;
    logic            res_valid_q, res_valid_d;
    logic [BITS-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;
    logic [TW-1:0]   tcnt_inc;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Saturating so a long result stall cannot wrap and shorten the period.
    assign tcnt_inc = (tcnt_q >= T_PERIOD) ? T_PERIOD : tcnt_q + TW'(1);

    // Next-state, counter and output-register decode for the conversion FSM.
    always_comb begin
        logic capture;
        capture     = 1'b0;
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        rr_d        = rr_q;
        win_d       = win_q;
        ack_d       = '0;
        adc_clk_d   = adc_clk_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d   = ST_PULSE;
                    tcnt_d    = TW'(1);
                    ack_d     = arb_grant;
                    adc_clk_d = 1'b1;
                    win_d     = arb_idx;
                    rr_d      = IDW'(wrap_inc(int'(arb_idx), NREQ));
                end
            end
            ST_PULSE: begin
                tcnt_d = tcnt_inc;
                if (tcnt_q == T_HIGH) begin
                    adc_clk_d = 1'b0;
                    // Equal high time and settle time: capture on the last high cycle.
                    if (SETTLE == CLK_HIGH) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                tcnt_d = tcnt_inc;
                if (tcnt_q == T_SETTLE) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                tcnt_d = tcnt_inc;
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    // Look at the next count so IDLE is reached in time for the
                    // following rise to land exactly PERIOD_MIN after this one.
                    state_d = (tcnt_inc >= T_PERIOD) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                tcnt_d = tcnt_inc;
                if (tcnt_inc >= T_PERIOD) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            res_data_d  = adc_data_i;
            res_id_d    = win_q;
            res_valid_d = 1'b1;
        end
    end

    // State, counter and registered outputs; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            rr_q        <= '0;
            win_q       <= '0;
            ack_q       <= '0;
            adc_clk_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            rr_q        <= rr_d;
            win_q       <= win_d;
            ack_q       <= ack_d;
            adc_clk_q   <= adc_clk_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign adc_clk_o     = adc_clk_q;
    assign bus.ack       = ack_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_sample_sched.sv
// Bench for adc_sample_sched. A timeline model predicts, from the rise time,
// handshake time and round-robin pointer, what every output should be in each
// cycle; scenario tasks add targeted checks on recorded observations.
module tb_adc_sample_sched;
    import adc_pkg::*;

    localparam int BITS       = ADC_BITS;
    localparam int NREQ       = 4;
    localparam int CLK_HIGH   = 4;
    localparam int SETTLE     = 6;
    localparam int PERIOD_MIN = 16;
    localparam int INF        = 1 << 30;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            adc_clk;
    logic [BITS-1:0] adc_data;

    adc_sample_sched_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

    adc_sample_sched #(
        .BITS       (BITS),
        .NREQ       (NREQ),
        .CLK_HIGH   (CLK_HIGH),
        .SETTLE     (SETTLE),
        .PERIOD_MIN (PERIOD_MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .adc_clk_o  (adc_clk),
        .adc_data_i (adc_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Timeline model of the conversion in flight.
    bit              m_active;
    int              m_rise, m_hs, m_idle, m_win, m_ptr, m_id;
    logic [BITS-1:0] m_data;

    // Observations for scenario checks.
    int              rise_q[$];
    int              ack_q[$];
    int              vcyc_q[$];
    int              vid_q[$];
    logic [BITS-1:0] vdata_q[$];
    logic            prev_clk, prev_valid;

    task automatic model_reset();
        m_active = 1'b0;
        m_rise   = INF;
        m_hs     = INF;
        m_idle   = INF;
        m_win    = 0;
        m_ptr    = 0;
        m_id     = 0;
        m_data   = '0;
    endtask

    task automatic clear_obs();
        rise_q.delete();
        ack_q.delete();
        vcyc_q.delete();
        vid_q.delete();
        vdata_q.delete();
    endtask

    // One clock cycle: compare the DUT with the model, then apply this cycle's inputs.
    task automatic run_cycle(input logic [NREQ-1:0] r, input logic rdy, input logic [BITS-1:0] d);
        logic            e_clk, e_valid, e_busy;
        logic [NREQ-1:0] e_ack;
        int              w;
        @(negedge clk);
        e_clk   = m_active && cyc >= m_rise && cyc < m_rise + CLK_HIGH;
        e_valid = m_active && cyc >= m_rise + SETTLE && cyc <= m_hs;
        e_busy  = m_active && cyc >= m_rise && cyc < m_idle;
        e_ack   = '0;
        if (m_active && cyc == m_rise) e_ack[m_win] = 1'b1;

        n_vec++;
        if (adc_clk !== e_clk) begin
            n_err++;
            $display("FAIL adc_clk cyc=%0d got=%b exp=%b", cyc, adc_clk, e_clk);
        end
        n_vec++;
        if (bus.ack !== e_ack) begin
            n_err++;
            $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, bus.ack, e_ack);
        end
        n_vec++;
        if (bus.busy !== e_busy) begin
            n_err++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e_busy);
        end
        n_vec++;
        if (bus.res_valid !== e_valid) begin
            n_err++;
            $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, bus.res_valid, e_valid);
        end
        if (e_valid) begin
            n_vec++;
            if (bus.res_data !== m_data) begin
                n_err++;
                $display("FAIL res_data cyc=%0d got=%h exp=%h", cyc, bus.res_data, m_data);
            end
            n_vec++;
            if (int'(bus.res_id) !== m_id) begin
                n_err++;
                $display("FAIL res_id cyc=%0d got=%0d exp=%0d", cyc, bus.res_id, m_id);
            end
        end

        if (adc_clk === 1'b1 && prev_clk !== 1'b1) rise_q.push_back(cyc);
        prev_clk = adc_clk;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i] === 1'b1) ack_q.push_back(i);
        end
        if (bus.res_valid === 1'b1 && prev_valid !== 1'b1) begin
            vcyc_q.push_back(cyc);
            vid_q.push_back(int'(bus.res_id));
            vdata_q.push_back(bus.res_data);
        end
        prev_valid = bus.res_valid;

        bus.req       = r;
        bus.res_ready = rdy;
        adc_data      = d;

        if (!rst_n) begin
            model_reset();
        end else if (!e_busy && (|r)) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_active = 1'b1;
            m_win    = w;
            m_rise   = cyc + 1;
            m_hs     = INF;
            m_idle   = INF;
            m_ptr    = (w + 1) % NREQ;
        end else if (m_active) begin
            if (cyc == m_rise + SETTLE - 1) begin
                m_data = d;
                m_id   = m_win;
            end
            if (e_valid && rdy) begin
                m_hs   = cyc;
                m_idle = (cyc + 1 > m_rise + PERIOD_MIN - 1) ? cyc + 1 : m_rise + PERIOD_MIN - 1;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) run_cycle('0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.res_ready = 1'b0;
        adc_data      = '0;
        model_reset();
        repeat (3) run_cycle('0, 1'b0, '0);
        n_vec++;
        if (bus.res_data !== '0 || bus.res_id !== '0) begin
            n_err++;
            $display("FAIL reset_result got=%h/%0d exp=00/0", bus.res_data, bus.res_id);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_conversion();
        int c0;
        clear_obs();
        c0 = cyc;
        run_cycle(4'b0001, 1'b1, 8'hA5);
        repeat (19) run_cycle('0, 1'b1, 8'hA5);
        n_vec++;
        if (rise_q.size() != 1 || rise_q[0] != c0 + 1) begin
            n_err++;
            $display("FAIL t1_rise got=%0d rises first=%0d exp=1 rise at %0d", rise_q.size(), rise_q[0], c0 + 1);
        end
        n_vec++;
        if (vcyc_q.size() != 1 || vcyc_q[0] != c0 + 7 || vdata_q[0] !== 8'hA5 || vid_q[0] != 0) begin
            n_err++;
            $display("FAIL t1_result got=%0d results at %0d data=%h id=%0d exp=1 at %0d data=a5 id=0",
                     vcyc_q.size(), vcyc_q[0], vdata_q[0], vid_q[0], c0 + 7);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        clear_obs();
        repeat (5 * PERIOD_MIN + 4) run_cycle(4'b1111, 1'b1, BITS'($urandom));
        repeat (20) run_cycle('0, 1'b1, BITS'($urandom));
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ack_q.size() <= i || ack_q[i] != exp_order[i]) begin
                n_err++;
                $display("FAIL t2_grant_order idx=%0d got=%0d exp=%0d", i, ack_q[i], exp_order[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rise_q.size() <= i + 1 || rise_q[i + 1] - rise_q[i] != PERIOD_MIN) begin
                n_err++;
                $display("FAIL t2_rise_spacing idx=%0d got=%0d exp=%0d", i, rise_q[i + 1] - rise_q[i], PERIOD_MIN);
            end
        end
    endtask

    task automatic test_backpressure();
        int c0;
        clear_obs();
        c0 = cyc;
        run_cycle(4'b0100, 1'b0, BITS'($urandom));
        repeat (46) run_cycle(4'b1000, 1'b0, BITS'($urandom));
        run_cycle(4'b1000, 1'b1, BITS'($urandom));
        run_cycle(4'b1000, 1'b1, BITS'($urandom));
        repeat (25) run_cycle('0, 1'b1, BITS'($urandom));
        n_vec++;
        if (rise_q.size() != 2 || rise_q[1] != c0 + 49) begin
            n_err++;
            $display("FAIL t3_next_rise got=%0d rises second=%0d exp=2 second at %0d", rise_q.size(), rise_q[1], c0 + 49);
        end
        n_vec++;
        if (vid_q.size() != 2 || vid_q[0] != 2 || vid_q[1] != 3) begin
            n_err++;
            $display("FAIL t3_ids got=%0d results ids %0d,%0d exp=2 results ids 2,3", vid_q.size(), vid_q[0], vid_q[1]);
        end
    endtask

    task automatic test_drop_and_pulse();
        clear_obs();
        run_cycle(4'b0100, 1'b1, 8'h3C);
        run_cycle(4'b0100, 1'b1, 8'h3C);
        run_cycle(4'b0000, 1'b1, 8'h3C);
        run_cycle(4'b0000, 1'b1, 8'h3C);
        run_cycle(4'b0000, 1'b1, 8'h3C);
        run_cycle(4'b0010, 1'b1, 8'h3C);
        repeat (25) run_cycle('0, 1'b1, 8'h3C);
        n_vec++;
        if (ack_q.size() != 1 || ack_q[0] != 2) begin
            n_err++;
            $display("FAIL t5_acks got=%0d acks first=%0d exp=1 ack id 2", ack_q.size(), ack_q[0]);
        end
        n_vec++;
        if (vid_q.size() != 1 || vid_q[0] != 2 || vdata_q[0] !== 8'h3C) begin
            n_err++;
            $display("FAIL t5_result got=%0d results id=%0d data=%h exp=1 result id 2 data 3c",
                     vid_q.size(), vid_q[0], vdata_q[0]);
        end
    endtask

    task automatic test_capture_window();
        logic [BITS-1:0] d;
        clear_obs();
        run_cycle(4'b0001, 1'b1, 8'h5A);
        for (int k = 1; k <= 25; k++) begin
            d = (k == 5) ? 8'h00 : (k == 6) ? 8'hFF : (k > 6) ? 8'h33 : 8'h5A;
            run_cycle('0, 1'b1, d);
        end
        n_vec++;
        if (vdata_q.size() != 1 || vdata_q[0] !== 8'hFF) begin
            n_err++;
            $display("FAIL t6_capture got=%0d results data=%h exp=1 result data ff", vdata_q.size(), vdata_q[0]);
        end
    endtask

    task automatic test_async_reset();
        clear_obs();
        run_cycle(4'b0001, 1'b1, BITS'($urandom));
        repeat (3) run_cycle('0, 1'b1, BITS'($urandom));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (adc_clk !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== '0) begin
            n_err++;
            $display("FAIL t4_async_reset got clk=%b busy=%b ack=%b exp=0/0/0", adc_clk, bus.busy, bus.ack);
        end
        repeat (2) run_cycle('0, 1'b1, BITS'($urandom));
        rst_n = 1'b1;
        repeat (25) run_cycle('0, 1'b1, BITS'($urandom));
        n_vec++;
        if (vcyc_q.size() != 0) begin
            n_err++;
            $display("FAIL t4_no_result got=%0d results exp=0", vcyc_q.size());
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            run_cycle(r, ($urandom_range(0, 3) != 0), BITS'($urandom));
        end
        repeat (40) run_cycle('0, 1'b1, BITS'($urandom));
    endtask

    initial begin
        prev_clk   = 1'b0;
        prev_valid = 1'b0;
        test_reset();
        test_single_conversion();
        test_round_robin();
        test_backpressure();
        test_drop_and_pulse();
        test_capture_window();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
